// File: rtl/przebieg_meter.sv
// Measures high time, low time and period of a single-bit waveform in iCLK cycles.
// Optional build macro PRZEBIEG_MINMAX_EN adds running min/max of the published period.
module przebieg_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iSIG,
  output logic [CNT_W-1:0] oHIGH_CNT,
  output logic [CNT_W-1:0] oLOW_CNT,
  output logic [CNT_W:0]   oPERIOD,
  output logic             oVALID,
  output logic             oSTUCK,
`ifdef PRZEBIEG_MINMAX_EN
  output logic [CNT_W:0]   oPER_MIN,
  output logic [CNT_W:0]   oPER_MAX,
`endif
  output logic             oLEVEL
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  // Returns {saturated, cnt+1}; saturated means one more cycle cannot be counted.
  function automatic logic [CNT_W:0] satIncr(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] nxt;
    nxt = c + CNT_ONE;
    return {(c == CNT_MAX), nxt};
  endfunction

  function automatic logic [CNT_W:0] sumPeriod(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic [SYNC_STAGES-1:0] syncChain_p0;
  logic [SYNC_STAGES-1:0] syncVld_p0;
  logic                   sLvl_p0;
  logic                   primed_p0;
  logic                   sDly_p1;
  logic                   rise_p1;
  logic                   fall_p1;
  state_t                 state_p2;
  logic [CNT_W-1:0]       cnt_p2;
  logic [CNT_W-1:0]       hiQ_p2;
  logic [CNT_W-1:0]       cntInc_p2;
  logic                   sat_p2;
  logic [CNT_W:0]         perNew_p2;

  // Stage p0: synchroniser. syncVld_p0 marks when the last stage holds a live
  // sample, so the reset-zeroed chain is never mistaken for a low level.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      syncChain_p0 <= '0;
      syncVld_p0   <= '0;
    end else begin
      syncChain_p0 <= {syncChain_p0[SYNC_STAGES-2:0], iSIG};
      syncVld_p0   <= {syncVld_p0[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sLvl_p0   = syncChain_p0[SYNC_STAGES-1];
  assign primed_p0 = syncVld_p0[SYNC_STAGES-1];
  assign oLEVEL    = sLvl_p0;

  // Stage p1: edge detection.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) sDly_p1 <= 1'b0;
    else         sDly_p1 <= sLvl_p0;
  end

  assign rise_p1 = sLvl_p0 & ~sDly_p1;
  assign fall_p1 = ~sLvl_p0 & sDly_p1;

  // Stage p2: phase counting, publication and saturation.
  assign {sat_p2, cntInc_p2} = satIncr(cnt_p2);
  assign perNew_p2           = sumPeriod(hiQ_p2, cnt_p2);

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_p2  <= IDLE;
      cnt_p2    <= '0;
      hiQ_p2    <= '0;
      oHIGH_CNT <= '0;
      oLOW_CNT  <= '0;
      oPERIOD   <= '0;
      oVALID    <= 1'b0;
      oSTUCK    <= 1'b0;
`ifdef PRZEBIEG_MINMAX_EN
      oPER_MIN  <= '1;
      oPER_MAX  <= '0;
`endif
    end else begin
      oVALID <= 1'b0;
      case (state_p2)
        IDLE: begin
          if (primed_p0 && !sLvl_p0) state_p2 <= ARM;
        end
        ARM: begin
          if (rise_p1) begin
            cnt_p2   <= CNT_ONE;
            state_p2 <= HIGH;
          end
        end
        HIGH: begin
          if (fall_p1) begin
            hiQ_p2   <= cnt_p2;
            cnt_p2   <= CNT_ONE;
            state_p2 <= LOW;
          end else if (sat_p2) begin
            oSTUCK   <= 1'b1;
            state_p2 <= IDLE;
          end else begin
            cnt_p2 <= cntInc_p2;
          end
        end
        LOW: begin
          if (rise_p1) begin
            oHIGH_CNT <= hiQ_p2;
            oLOW_CNT  <= cnt_p2;
            oPERIOD   <= perNew_p2;
            oVALID    <= 1'b1;
            oSTUCK    <= 1'b0;
`ifdef PRZEBIEG_MINMAX_EN
            if (perNew_p2 < oPER_MIN) oPER_MIN <= perNew_p2;
            if (perNew_p2 > oPER_MAX) oPER_MAX <= perNew_p2;
`endif
            cnt_p2    <= CNT_ONE;
            state_p2  <= HIGH;
          end else if (sat_p2) begin
            oSTUCK   <= 1'b1;
            state_p2 <= IDLE;
          end else begin
            cnt_p2 <= cntInc_p2;
          end
        end
        default: state_p2 <= IDLE;
      endcase
    end
  end

endmodule
